// File: rtl/bus_cmp_pkg.sv
// -----------------------------------------------------------------------------
// bus_cmp_pkg
// Shared definitions for the redundant-bus frame comparator:
//   - default values for DW, FIFO_DEPTH and TIMEOUT
//   - FSM state encoding
//   - bit positions inside the modStatus judgement word
// -----------------------------------------------------------------------------
package bus_cmp_pkg;

  localparam int DEF_DW         = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COMPARE = 2'd2,
    ST_REPORT  = 2'd3
  } cmpState_t;

  // modStatus bit positions
  localparam int MS_NEW       = 0;  // toggles on every report
  localparam int MS_MATCH     = 1;  // frame matched
  localparam int MS_ERROR     = 2;  // frame mismatched or timed out
  localparam int MS_TIMEOUT   = 3;  // reported frame timed out
  localparam int MS_OVERFLOW  = 4;  // sticky FIFO overflow
  localparam int MS_ERRCNT_LO = 5;  // consecutive error count, bits [7:5]
  localparam int MS_ERRCNT_HI = 7;

  localparam logic [2:0] ERRCNT_MAX = 3'd7;

endpackage

// File: rtl/bus_cmp_fifo.sv
// -----------------------------------------------------------------------------
// bus_cmp_fifo
// Synchronous single-clock FIFO with an array-inferred memory and a registered
// read port: a pop loads rdData on the clock edge, so the popped entry is
// visible in the cycle after the pop.
//
// Ports
//   clk2     in   clock, rising edge
//   rst      in   synchronous active-high reset (empties FIFO, clears overflow)
//   flush    in   empties the FIFO (overflow flag is kept)
//   wrEn     in   write strobe
//   wrData   in   W-bit write data
//   rdEn     in   pop strobe (ignored when empty)
//   rdData   out  W-bit registered read data
//   full     out  FIFO holds DEPTH entries
//   empty    out  FIFO holds no entries
//   overflow out  sticky: a write was dropped because the FIFO was full
//
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module bus_cmp_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk2,
  input  logic         rst,
  input  logic         flush,
  input  logic         wrEn,
  input  logic [W-1:0] wrData,
  input  logic         rdEn,
  output logic [W-1:0] rdData,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtrReg;
  logic [AW-1:0] rdPtrReg;
  logic [AW:0]   countReg;
  logic          doWr;
  logic          doRd;

  assign full  = (countReg == (AW+1)'(DEPTH));
  assign empty = (countReg == '0);
  assign doRd  = rdEn && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign doWr  = wrEn && (!full || doRd);

  always_ff @(posedge clk2) begin
    if (doWr && !rst && !flush) begin
      mem[wrPtrReg] <= wrData;
    end
  end

  always_ff @(posedge clk2) begin
    if (doRd) begin
      rdData <= mem[rdPtrReg];
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doWr) wrPtrReg <= wrPtrReg + 1'b1;
      if (doRd) rdPtrReg <= rdPtrReg + 1'b1;
      countReg <= countReg + (AW+1)'(doWr) - (AW+1)'(doRd);
      if (wrEn && !doWr) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/bus_frame_comparator.sv
// -----------------------------------------------------------------------------
// bus_frame_comparator
// Compares frames received on two redundant bus channels byte by byte and
// publishes a judgement status word after every frame.
//
// Each channel's bytes (with their last flag) are buffered in a bus_cmp_fifo.
// The FSM (IDLE / WAIT / COMPARE / REPORT) pops both FIFOs together while
// both hold data. Because the FIFO read port is registered, the comparison of
// an entry happens in the cycle after its pop; the frame ends when a compared
// entry carries last=1 on either side, and no further pop is issued in that
// cycle so surplus bytes of the longer frame stay queued for the next frame.
//
// Ports
//   clk2         in   clock, rising edge
//   rst          in   synchronous active-high reset
//   chA_valid    in   byte strobe, channel A
//   chA_data     in   DW-bit byte, channel A
//   chA_last     in   last byte of frame, channel A
//   chB_valid    in   byte strobe, channel B
//   chB_data     in   DW-bit byte, channel B
//   chB_last     in   last byte of frame, channel B
//   compResultEn out  comparison busy (WAIT, COMPARE, REPORT)
//   modStatus    out  {errCnt[2:0], overflow, timeout, error, match, newResult}
//
// Build option: define BUS_FRAME_CMP_TIMEOUT_EN to compile in the lead
// counter. When one channel leads the other for TIMEOUT cycles, both FIFOs
// are flushed and the frame is reported as timed out. Without the macro the
// FSM waits indefinitely for the lagging channel and modStatus[3] reads 0.
// -----------------------------------------------------------------------------
module bus_frame_comparator
  import bus_cmp_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic          clk2,
  input  logic          rst,
  input  logic          chA_valid,
  input  logic [DW-1:0] chA_data,
  input  logic          chA_last,
  input  logic          chB_valid,
  input  logic [DW-1:0] chB_data,
  input  logic          chB_last,
  output logic          compResultEn,
  output logic [7:0]    modStatus
);

  // Channel-indexed views: index 0 = A, index 1 = B
  logic [1:0]    chValid;
  logic [1:0]    chLast;
  logic [DW-1:0] chData [2];
  logic [DW:0]   rdData [2];
  logic [1:0]    fifoFull;
  logic [1:0]    fifoEmpty;
  logic [1:0]    fifoOvf;

  logic pop;
  logic flush;

  assign chValid   = {chB_valid, chA_valid};
  assign chLast    = {chB_last,  chA_last};
  assign chData[0] = chA_data;
  assign chData[1] = chB_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gChan
      bus_cmp_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH)
      ) uFifo (
        .clk2     (clk2),
        .rst      (rst),
        .flush    (flush),
        .wrEn     (chValid[gi]),
        .wrData   ({chLast[gi], chData[gi]}),
        .rdEn     (pop),
        .rdData   (rdData[gi]),
        .full     (fifoFull[gi]),
        .empty    (fifoEmpty[gi]),
        .overflow (fifoOvf[gi])
      );
    end
  endgenerate

  // Pops are only issued while both FIFOs hold data and a full FIFO accepts a
  // write that coincides with a pop, so the comparator has no use for full.
  logic unusedFull;
  assign unusedFull = &fifoFull;

  cmpState_t   stateReg, stateNext;
  logic        cmpValidReg;        // rdData holds a freshly popped pair
  logic        mismReg, mismNext;  // frame-mismatch flag
  logic [3:0]  statReg, statNext;  // modStatus[3:0]
  logic [2:0]  errCntReg, errCntNext;

  logic bothAvail;
  logic anyAvail;
  logic frameEnd;
  logic timeoutFire;
  logic reportTimeout;

  assign bothAvail = !fifoEmpty[0] && !fifoEmpty[1];
  assign anyAvail  = !fifoEmpty[0] || !fifoEmpty[1];
  assign frameEnd  = cmpValidReg && (rdData[0][DW] || rdData[1][DW]);

`ifdef BUS_FRAME_CMP_TIMEOUT_EN
  localparam int LW = $clog2(TIMEOUT + 1);

  logic [LW-1:0] leadReg;
  logic          toReg;
  logic          leadInc;

  // The lead counter runs in every WAIT cycle and in COMPARE cycles that
  // stall for lack of data on one channel.
  assign leadInc       = (stateReg == ST_WAIT) ||
                         ((stateReg == ST_COMPARE) && !frameEnd && !bothAvail);
  assign timeoutFire   = leadInc && !bothAvail && (leadReg >= LW'(TIMEOUT - 1));
  assign reportTimeout = toReg;

  always_ff @(posedge clk2) begin
    if (rst || (stateReg == ST_REPORT)) begin
      leadReg <= '0;
      toReg   <= 1'b0;
    end else begin
      if (leadInc && (leadReg < LW'(TIMEOUT))) leadReg <= leadReg + 1'b1;
      if (timeoutFire) toReg <= 1'b1;
    end
  end
`else
  assign timeoutFire   = 1'b0;
  assign reportTimeout = 1'b0;
`endif

  always_comb begin
    stateNext  = stateReg;
    pop        = 1'b0;
    flush      = 1'b0;
    mismNext   = mismReg;
    statNext   = statReg;
    errCntNext = errCntReg;

    case (stateReg)
      ST_IDLE: begin
        if (bothAvail)     stateNext = ST_COMPARE;
        else if (anyAvail) stateNext = ST_WAIT;
      end

      ST_WAIT: begin
        if (bothAvail) stateNext = ST_COMPARE;
      end

      ST_COMPARE: begin
        if (cmpValidReg && (rdData[0] != rdData[1])) mismNext = 1'b1;
        if (frameEnd)       stateNext = ST_REPORT;
        else if (bothAvail) pop = 1'b1;
      end

      ST_REPORT: begin
        statNext[MS_NEW]     = ~statReg[MS_NEW];
        statNext[MS_MATCH]   = ~mismReg;
        statNext[MS_ERROR]   = mismReg;
        statNext[MS_TIMEOUT] = reportTimeout;
        if (!mismReg)                     errCntNext = 3'd0;
        else if (errCntReg != ERRCNT_MAX) errCntNext = errCntReg + 3'd1;
        mismNext  = 1'b0;
        stateNext = ST_IDLE;
      end

      default: stateNext = ST_IDLE;
    endcase

    // A timed-out frame counts as a mismatch and discards everything queued.
    if (timeoutFire) begin
      flush     = 1'b1;
      mismNext  = 1'b1;
      stateNext = ST_REPORT;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      stateReg    <= ST_IDLE;
      cmpValidReg <= 1'b0;
      mismReg     <= 1'b0;
      statReg     <= '0;
      errCntReg   <= '0;
    end else begin
      stateReg    <= stateNext;
      cmpValidReg <= pop;
      mismReg     <= mismNext;
      statReg     <= statNext;
      errCntReg   <= errCntNext;
    end
  end

  assign compResultEn = (stateReg != ST_IDLE);

  // The overflow bit is a live view of the sticky FIFO flags; the other bits
  // change only when a frame is reported.
  assign modStatus = {errCntReg, (fifoOvf[0] | fifoOvf[1]), statReg};

endmodule

// File: tb/tb_bus_frame_comparator.sv
// -----------------------------------------------------------------------------
// tb_bus_frame_comparator
// Directed bench for bus_frame_comparator with hand-computed expectations.
// Inputs change 1 time unit after each rising clk2 edge; outputs are sampled
// at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_bus_frame_comparator;

  logic       clk2 = 1'b0;
  logic       rst;
  logic       chA_valid, chB_valid;
  logic [7:0] chA_data,  chB_data;
  logic       chA_last,  chB_last;
  logic       compResultEn;
  logic [7:0] modStatus;

  int testsRun    = 0;
  int testsFailed = 0;
  int busyCnt     = 0;

  logic [7:0] frmA [8];
  logic [7:0] frmB [8];
  logic [7:0] expMis [8];

  always #5 clk2 = ~clk2;

  bus_frame_comparator dut (
    .clk2         (clk2),
    .rst          (rst),
    .chA_valid    (chA_valid),
    .chA_data     (chA_data),
    .chA_last     (chA_last),
    .chB_valid    (chB_valid),
    .chB_data     (chB_data),
    .chB_last     (chB_last),
    .compResultEn (compResultEn),
    .modStatus    (modStatus)
  );

  task automatic cyc();
    @(posedge clk2);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    chA_valid = 1'b0; chA_data = 8'h00; chA_last = 1'b0;
    chB_valid = 1'b0; chB_data = 8'h00; chB_last = 1'b0;
  endtask

  // Sends frmA[0..nA-1] on A from cycle 0 and frmB[0..nB-1] on B from cycle
  // offB, last flag on the final byte of each; busyCnt accumulates the
  // number of sampled cycles with compResultEn high.
  task automatic runFrame(input int nA, input int nB, input int offB);
    int total;
    int idx;
    total = ((nA > offB + nB) ? nA : offB + nB) + 8;
    for (int t = 0; t < total; t++) begin
      chA_valid = (t < nA);
      chA_data  = (t < nA) ? frmA[t] : 8'h00;
      chA_last  = (t == nA - 1);
      idx       = t - offB;
      chB_valid = (idx >= 0) && (idx < nB);
      chB_data  = ((idx >= 0) && (idx < nB)) ? frmB[idx] : 8'h00;
      chB_last  = (idx == nB - 1);
      cyc();
      if (compResultEn) busyCnt++;
    end
    idleInputs();
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    expMis[0] = 8'h24; expMis[1] = 8'h45; expMis[2] = 8'h64; expMis[3] = 8'h85;
    expMis[4] = 8'hA4; expMis[5] = 8'hC5; expMis[6] = 8'hE4; expMis[7] = 8'hE5;

    // Reset state
    cyc(); cyc();
    check("reset_status", 32'(modStatus), 32'h00);
    check("reset_busy", 32'(compResultEn), 32'h0);
    rst = 1'b0;
    cyc();

    // Identical 3-byte frames on both channels in the same cycles
    frmA[0] = 8'hA1; frmA[1] = 8'hA2; frmA[2] = 8'hA3;
    frmB[0] = 8'hA1; frmB[1] = 8'hA2; frmB[2] = 8'hA3;
    busyCnt = 0;
    runFrame(3, 3, 0);
    check("match_busy_cycles", 32'(busyCnt), 32'd5);
    check("match_status", 32'(modStatus), 32'h03);

    // Mismatching middle byte, eight times: error count saturates at 7
    frmA[0] = 8'h11; frmA[1] = 8'h22; frmA[2] = 8'h33;
    frmB[0] = 8'h11; frmB[1] = 8'h2F; frmB[2] = 8'h33;
    for (int k = 0; k < 8; k++) begin
      runFrame(3, 3, 0);
      check($sformatf("mismatch_status_%0d", k), 32'(modStatus), 32'(expMis[k]));
    end

    // B lags A by 3 cycles, identical data
    frmA[0] = 8'h5A; frmA[1] = 8'h6B; frmA[2] = 8'h7C;
    frmB[0] = 8'h5A; frmB[1] = 8'h6B; frmB[2] = 8'h7C;
    busyCnt = 0;
    runFrame(3, 3, 3);
    check("lag3_busy_cycles", 32'(busyCnt), 32'd8);
    check("lag3_status", 32'(modStatus), 32'h02);
    check("lag3_timeout_bit", 32'(modStatus[3]), 32'h0);

    // Last flags differ: B's surplus byte stays queued and pairs with the
    // next single-byte A frame
    frmA[0] = 8'h05; frmA[1] = 8'h06;
    frmB[0] = 8'h05; frmB[1] = 8'h06; frmB[2] = 8'h07;
    runFrame(2, 3, 0);
    check("last_differ_status", 32'(modStatus), 32'h25);
    frmA[0] = 8'h07;
    runFrame(1, 0, 0);
    check("surplus_match_status", 32'(modStatus), 32'h02);

    // Reset asserted during COMPARE discards the partial frame
    chA_valid = 1'b1; chA_data = 8'h41; chA_last = 1'b0;
    chB_valid = 1'b1; chB_data = 8'h41; chB_last = 1'b0;
    cyc();
    chA_data = 8'h42; chB_data = 8'h42;
    cyc();
    check("pre_reset_busy", 32'(compResultEn), 32'h1);
    rst = 1'b1;
    chA_data = 8'h43; chA_last = 1'b1;
    chB_data = 8'h43; chB_last = 1'b1;
    cyc();
    check("midframe_reset_status", 32'(modStatus), 32'h00);
    check("midframe_reset_busy", 32'(compResultEn), 32'h0);
    rst = 1'b0;
    idleInputs();
    cyc(); cyc(); cyc();
    check("post_reset_fifos_empty", 32'(compResultEn), 32'h0);
    frmA[0] = 8'h91; frmA[1] = 8'h92; frmA[2] = 8'h93;
    frmB[0] = 8'h91; frmB[1] = 8'h92; frmB[2] = 8'h93;
    runFrame(3, 3, 0);
    check("post_reset_match_status", 32'(modStatus), 32'h03);

    // Five A bytes, B silent, depth 4: fifth byte dropped, overflow sticky
    frmA[0] = 8'hC1; frmA[1] = 8'hC2; frmA[2] = 8'hC3; frmA[3] = 8'hC4; frmA[4] = 8'hC5;
    busyCnt = 0;
    runFrame(5, 0, 0);
    check("overflow_status", 32'(modStatus), 32'h13);
    for (int t = 0; t < 20; t++) begin
      cyc();
      if (compResultEn) busyCnt++;
    end
`ifdef BUS_FRAME_CMP_TIMEOUT_EN
    check("timeout_busy_cycles", 32'(busyCnt), 32'd17);
    check("timeout_status", 32'(modStatus), 32'h3C);
    check("timeout_fifos_flushed", 32'(compResultEn), 32'h0);
`else
    check("no_timeout_busy", 32'(compResultEn), 32'h1);
    check("no_timeout_status", 32'(modStatus), 32'h13);
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("overflow_cleared_by_reset", 32'(modStatus), 32'h00);
    check("overflow_reset_busy", 32'(compResultEn), 32'h0);
    frmA[0] = 8'hE1; frmA[1] = 8'hE2; frmA[2] = 8'hE3;
    frmB[0] = 8'hE1; frmB[1] = 8'hE2; frmB[2] = 8'hE3;
    runFrame(3, 3, 0);
    check("final_match_status", 32'(modStatus), 32'h03);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bus_frame_comparator.md
BUS_FRAME_COMPARATOR -- requirements
Module: bus_frame_comparator

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the bus data width per channel.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the per-channel buffer depth in entries (power of two).
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles one channel may lead the other.
REQ-004 SHALL have port clk2, input, 1 bit: the clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have ports chA_valid / chB_valid, input, 1 bit each: byte strobe from redundant bus channel A / B.
REQ-007 SHALL have ports chA_data / chB_data, input, DW bits each: bus byte, qualified by valid.
REQ-008 SHALL have ports chA_last / chB_last, input, 1 bit each: last byte of frame, qualified by valid.
REQ-009 SHALL have port compResultEn, output, 1 bit: comparison busy; result not yet final.
REQ-010 SHALL have port modStatus, output, 8 bits: the judgement status word.

Function
REQ-011 SHALL write each valid byte, with its last flag, into that channel's FIFO in the same cycle; a write with the FIFO full SHALL drop the byte and set the sticky overflow flag.
REQ-012 SHALL run the FSM states IDLE, WAIT, COMPARE and REPORT.
REQ-013 IDLE: both FIFOs non-empty -> COMPARE; exactly one non-empty -> WAIT.
REQ-014 WAIT: both FIFOs non-empty -> COMPARE; the lead counter SHALL increment each WAIT cycle.
REQ-015 COMPARE: when both FIFOs are non-empty, SHALL pop one entry from each in the same cycle and set the frame-mismatch flag if data or last differ; no pop when either FIFO is empty (the lead counter runs as in WAIT).
REQ-016 Frame end SHALL occur when either popped entry carries last=1; the next state is REPORT. Surplus bytes of the longer frame SHALL be left in the FIFO for the next frame.
REQ-017 REPORT, one cycle: SHALL update modStatus, clear the frame-mismatch flag and lead counter, and go to IDLE.
REQ-018 modStatus[0] SHALL toggle on every REPORT (new-result marker).
REQ-019 modStatus[1] SHALL be 1 when the frame matched.
REQ-020 modStatus[2] SHALL be 1 when the frame mismatched or timed out; this is the error bit consumed downstream.
REQ-021 modStatus[3] SHALL be the timeout bit of the reported frame.
REQ-022 modStatus[4] SHALL be the sticky FIFO overflow bit, cleared only by reset.
REQ-023 modStatus[7:5] SHALL hold the consecutive error-frame count, saturating at 7 and cleared by a matching report.
REQ-024 compResultEn SHALL be 1 in every WAIT, COMPARE and REPORT cycle and 0 in IDLE.
REQ-025 A simultaneous write and pop on the same FIFO SHALL both take effect, leaving occupancy unchanged; a write to a full FIFO with a simultaneous pop SHALL be accepted.
REQ-026 modStatus SHALL hold its value between REPORT cycles.

Reset
REQ-027 With rst=1, SHALL set modStatus=8'h00, compResultEn=0, FSM=IDLE, both FIFOs empty, and all counters and flags cleared; this takes effect on the next clk2 edge.
REQ-028 Assertion of rst mid-frame SHALL discard the partial frame with no REPORT; valid inputs SHALL be ignored while rst=1.

Configuration
REQ-029 SHALL use macro BUS_FRAME_CMP_TIMEOUT_EN to compile the timeout feature in or out.
REQ-030 With BUS_FRAME_CMP_TIMEOUT_EN defined: lead counter reaching TIMEOUT SHALL flush both FIFOs, set timeout and mismatch, and enter REPORT.
REQ-031 Without BUS_FRAME_CMP_TIMEOUT_EN: no lead counter, modStatus[3] tied 0, and WAIT SHALL persist indefinitely.

Structure
REQ-032 Package bus_cmp_pkg SHALL hold the FSM state encoding, the modStatus bit-index constants and the default DW, FIFO_DEPTH and TIMEOUT values.
REQ-033 SHALL instantiate sub-module bus_cmp_fifo twice, once per channel: synchronous, DW+1 bits wide, with full/empty flags and overflow flag.

Verification
REQ-034 Identical 3-byte frames on A and B, same cycles -> compResultEn high for 5 cycles, then modStatus=8'h03.
REQ-035 Frames A=11,22,33 and B=11,2F,33 -> modStatus[2]=1, [1]=0, [7:5]=1; repeating the pair 7 more times keeps [7:5]=7.
REQ-036 B frame starts 3 cycles after A, identical data -> WAIT for 3 cycles, then match reported with [3]=0.
REQ-037 A frame only, B silent, macro defined -> REPORT after 16 WAIT cycles with [3]=1, [2]=1, both FIFOs empty; macro undefined -> compResultEn stays 1 and no REPORT occurs.
REQ-038 Five A bytes written with B silent and FIFO_DEPTH=4 -> fifth byte dropped and [4]=1 until rst.
REQ-039 rst asserted during COMPARE -> next cycle modStatus=8'h00, compResultEn=0; a subsequent matching frame -> modStatus=8'h03.
